// File: rtl/core_ctrl.sv
// core_ctrl: condition-code sequencer between the host start/status interface,
// the memory controller and the processing-unit cluster.
// Ports:
//   cc_clk, cc_reset            clock, asynchronous active-high reset
//   cc_start, cc_length         host start request and last-address index
//   cc_mc_done, cc_mc_data_done memory controller done / end-of-memory flag
//   cc_pu_done                  processing units finished the current batch
//   cc_data_condition           condition code to the memory controller
//   cc_data_length              latched (clamped) length to the memory controller
//   cc_pu_start                 one-cycle launch pulse to the processing units
//   cc_busy, cc_finished        status: running / one-cycle normal completion
//   cc_error                    sticky watchdog abort flag
//   cc_batch_count              batches completed in the current run
module core_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter logic [5:0]  MEM_LENGTH     = 6'd31
) (
  input  logic       cc_clk,
  input  logic       cc_reset,
  input  logic       cc_start,
  input  logic [5:0] cc_length,
  input  logic       cc_mc_done,
  input  logic       cc_mc_data_done,
  input  logic       cc_pu_done,
  output logic [2:0] cc_data_condition,
  output logic [5:0] cc_data_length,
  output logic       cc_pu_start,
  output logic       cc_busy,
  output logic       cc_finished,
  output logic       cc_error,
  output logic [6:0] cc_batch_count
);

  localparam int unsigned WD_W  = 16;
  localparam int unsigned CNT_W = 7;

  localparam logic [2:0] CC_IDLE    = 3'b000;
  localparam logic [2:0] CC_LOAD    = 3'b100;
  localparam logic [2:0] CC_PROCESS = 3'b001;
  localparam logic [2:0] CC_NEXT    = 3'b010;
  localparam logic [2:0] CC_HOLD    = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_FETCH, S_PROC, S_FINISH, S_ABORT1, S_ABORT2, S_ABORT3
  } state_t;

  state_t            state, state_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic              dd, dd_n;
  logic [2:0]        cond_n;
  logic [5:0]        len_n;
  logic              pus_n, busy_n, fin_n, err_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout, last_batch;

  assign timeout    = (wd == TIMEOUT_CYCLES - 16'd1);
  assign cnt_inc    = cc_batch_count + CNT_W'(1);
  assign last_batch = (cnt_inc == (CNT_W'(cc_data_length) + CNT_W'(1)));

  // State and registered outputs
  always_ff @(posedge cc_clk or posedge cc_reset) begin
    if (cc_reset) begin
      state             <= S_IDLE;
      wd                <= '0;
      dd                <= 1'b0;
      cc_data_condition <= CC_IDLE;
      cc_data_length    <= '0;
      cc_pu_start       <= 1'b0;
      cc_busy           <= 1'b0;
      cc_finished       <= 1'b0;
      cc_error          <= 1'b0;
      cc_batch_count    <= '0;
    end else begin
      state             <= state_n;
      wd                <= wd_n;
      dd                <= dd_n;
      cc_data_condition <= cond_n;
      cc_data_length    <= len_n;
      cc_pu_start       <= pus_n;
      cc_busy           <= busy_n;
      cc_finished       <= fin_n;
      cc_error          <= err_n;
      cc_batch_count    <= cnt_n;
    end
  end

  // Next state; the output registers show the code of the cycle being entered
  always_comb begin
    state_n = state;
    cond_n  = cc_data_condition;
    len_n   = cc_data_length;
    pus_n   = 1'b0;
    fin_n   = 1'b0;
    err_n   = cc_error;
    cnt_n   = cc_batch_count;
    dd_n    = dd | ((state != S_IDLE) && cc_mc_data_done);
    wd_n    = '0;
    busy_n  = 1'b0;

    case (state)
      S_IDLE: begin
        cond_n = CC_IDLE;
        if (cc_start) begin
          len_n   = (cc_length > MEM_LENGTH) ? MEM_LENGTH : cc_length;
          cnt_n   = '0;
          err_n   = 1'b0;
          dd_n    = 1'b0;
          state_n = S_STORE;
          cond_n  = CC_LOAD;
        end
      end
      S_STORE: begin
        cond_n = CC_LOAD;
        if (cc_mc_done) begin
          state_n = S_FETCH;
          cond_n  = CC_HOLD;
        end else if (timeout) begin
          state_n = S_ABORT1;
          cond_n  = CC_NEXT;
          err_n   = 1'b1;
        end
      end
      S_FETCH: begin
        cond_n = CC_HOLD;
        // wd is zero only in the entry cycle, where mc_done is still stale
        if (cc_mc_done && (wd != '0)) begin
          state_n = S_PROC;
          cond_n  = CC_PROCESS;
          pus_n   = 1'b1;
        end else if (timeout) begin
          state_n = S_ABORT1;
          cond_n  = CC_NEXT;
          err_n   = 1'b1;
        end
      end
      S_PROC: begin
        cond_n = CC_HOLD;
        if (cc_pu_done) begin
          cnt_n = cnt_inc;
          if (last_batch || dd || cc_mc_data_done) begin
            state_n = S_FINISH;
            cond_n  = CC_IDLE;
            fin_n   = 1'b1;
          end else begin
            state_n = S_FETCH;
            cond_n  = CC_NEXT;
          end
        end else if (timeout) begin
          state_n = S_ABORT1;
          cond_n  = CC_NEXT;
          err_n   = 1'b1;
        end
      end
      S_FINISH: begin
        state_n = S_IDLE;
        cond_n  = CC_IDLE;
      end
      S_ABORT1: begin
        state_n = S_ABORT2;
        cond_n  = CC_PROCESS;
      end
      S_ABORT2: begin
        state_n = S_ABORT3;
        cond_n  = CC_IDLE;
      end
      S_ABORT3: begin
        state_n = S_IDLE;
        cond_n  = CC_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cond_n  = CC_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
    // Watchdog restarts on every state change and runs only in waiting phases
    if ((state_n == state) &&
        ((state == S_STORE) || (state == S_FETCH) || (state == S_PROC))) begin
      wd_n = wd + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: open-loop bench for core_ctrl. For each run a reference model
// builds the full per-cycle output trace and input schedule from the run's
// parameters (length, response delays, data-done/timeout injections); the
// bench then plays the inputs and compares every output on every cycle.
module tb_core_ctrl;

  localparam int          TI   = 8;
  localparam logic [15:0] TOUT = 16'd8;
  localparam int          MAXC = 2048;

  logic       cc_clk, cc_reset, cc_start, cc_mc_done, cc_mc_data_done, cc_pu_done;
  logic [5:0] cc_length;
  logic [2:0] cc_data_condition;
  logic [5:0] cc_data_length;
  logic       cc_pu_start, cc_busy, cc_finished, cc_error;
  logic [6:0] cc_batch_count;

  core_ctrl #(.TIMEOUT_CYCLES(TOUT), .MEM_LENGTH(6'd31)) dut (
    .cc_clk(cc_clk), .cc_reset(cc_reset), .cc_start(cc_start),
    .cc_length(cc_length), .cc_mc_done(cc_mc_done),
    .cc_mc_data_done(cc_mc_data_done), .cc_pu_done(cc_pu_done),
    .cc_data_condition(cc_data_condition), .cc_data_length(cc_data_length),
    .cc_pu_start(cc_pu_start), .cc_busy(cc_busy), .cc_finished(cc_finished),
    .cc_error(cc_error), .cc_batch_count(cc_batch_count)
  );

  initial begin
    cc_clk = 1'b0;
    forever #5 cc_clk = ~cc_clk;
  end

  int ntests = 0;
  int nfail  = 0;
  int cur    = 0;

  // Expected trace and input schedule
  logic [2:0] e_cond [MAXC];
  bit         e_busy [MAXC], e_pus [MAXC], e_fin [MAXC], e_err [MAXC];
  logic [6:0] e_cnt  [MAXC];
  logic [5:0] e_len  [MAXC];
  bit         i_start[MAXC], i_mcd[MAXC], i_pud[MAXC], i_dd[MAXC];
  int         n;

  // Run parameters
  int s_d;
  int f_d [64];
  int p_d [64];
  int dd_batch;
  bit dd_in_last;

  // Persistent model state across runs
  bit m_err = 1'b0;
  int m_cnt = 0;
  int m_len = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  task automatic emit(input logic [2:0] c, input bit b, input bit ps, input bit fi,
                      input bit md, input bit pd);
    e_cond[n] = c;  e_busy[n] = b;  e_pus[n] = ps;  e_fin[n] = fi;
    e_err[n]  = m_err;
    e_cnt[n]  = 7'(m_cnt);
    e_len[n]  = 6'(m_len);
    i_start[n] = (n == 0);
    i_mcd[n]   = md;
    i_pud[n]   = pd;
    i_dd[n]    = 1'b0;
    n++;
  endtask

  task automatic emit_abort();
    m_err = 1'b1;
    emit(3'b010, 1, 0, 0, 0, 0);
    emit(3'b001, 1, 0, 0, 0, 0);
    emit(3'b000, 1, 0, 0, 0, 0);
    emit(3'b000, 0, 0, 0, 0, 0);
  endtask

  // Build the whole run from the sequencing rules
  task automatic plan(input int len);
    int  nb;
    bit  ddf;
    n = 0;
    ddf = 1'b0;
    emit(3'b000, 0, 0, 0, 0, 0);
    m_len = (len > 31) ? 31 : len;
    m_cnt = 0;
    m_err = 1'b0;
    nb = m_len + 1;
    if (s_d > TI) begin
      for (int k = 1; k <= TI; k++) emit(3'b100, 1, 0, 0, 0, 0);
      emit_abort();
      return;
    end
    for (int k = 1; k <= s_d; k++) emit(3'b100, 1, 0, 0, k == s_d, 0);
    for (int b = 0; b < 64; b++) begin
      if (f_d[b] > TI) begin
        for (int k = 1; k <= TI; k++)
          emit((k == 1 && b > 0) ? 3'b010 : 3'b011, 1, 0, 0, 0, 0);
        emit_abort();
        return;
      end
      for (int k = 1; k <= f_d[b]; k++)
        emit((k == 1 && b > 0) ? 3'b010 : 3'b011, 1, 0, 0, k == f_d[b], 0);
      if (p_d[b] > TI) begin
        for (int k = 1; k <= TI; k++)
          emit((k == 1) ? 3'b001 : 3'b011, 1, k == 1, 0, 0, 0);
        emit_abort();
        return;
      end
      for (int k = 1; k <= p_d[b]; k++) begin
        emit((k == 1) ? 3'b001 : 3'b011, 1, k == 1, 0, 0, k == p_d[b]);
        if (b == dd_batch && k == (dd_in_last ? p_d[b] : 1)) begin
          i_dd[n-1] = 1'b1;
          ddf = 1'b1;
        end
      end
      m_cnt++;
      if (m_cnt == nb || ddf) begin
        emit(3'b000, 1, 0, 1, 0, 0);
        emit(3'b000, 0, 0, 0, 0, 0);
        return;
      end
    end
  endtask

  // Extra start pulse during the first PROC cycle; it must change nothing
  task automatic add_busy_start();
    for (int k = 1; k < n; k++) begin
      if (e_pus[k]) begin
        i_start[k] = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_cycle(input int k);
    cur = k;
    chk("cond",   16'(cc_data_condition), 16'(e_cond[k]));
    chk("busy",   16'(cc_busy),           16'(e_busy[k]));
    chk("pu_start", 16'(cc_pu_start),     16'(e_pus[k]));
    chk("finished", 16'(cc_finished),     16'(e_fin[k]));
    chk("error",  16'(cc_error),          16'(e_err[k]));
    chk("batch_count", 16'(cc_batch_count), 16'(e_cnt[k]));
    chk("data_length", 16'(cc_data_length), 16'(e_len[k]));
  endtask

  task automatic exec(input int len, input int limit);
    for (int k = 0; k < limit && k < n; k++) begin
      @(posedge cc_clk);
      #1;
      check_cycle(k);
      cc_start        = i_start[k];
      cc_length       = 6'(len);
      cc_mc_done      = i_mcd[k];
      cc_pu_done      = i_pud[k];
      cc_mc_data_done = i_dd[k];
    end
  endtask

  task automatic clear_in();
    cc_start = 0; cc_mc_done = 0; cc_pu_done = 0; cc_mc_data_done = 0;
  endtask

  task automatic set_delays(input int s, input int f, input int p);
    s_d = s;
    for (int b = 0; b < 64; b++) begin
      f_d[b] = f;
      p_d[b] = p;
    end
    dd_batch = -1;
    dd_in_last = 1'b0;
  endtask

  task automatic rand_delays();
    s_d = ($urandom_range(7, 0) == 0) ? TI + 1 : int'($urandom_range(TI, 1));
    for (int b = 0; b < 64; b++) begin
      f_d[b] = ($urandom_range(40, 0) == 0) ? TI + 1 : int'($urandom_range(TI, 2));
      p_d[b] = ($urandom_range(40, 0) == 0) ? TI + 1 : int'($urandom_range(TI, 1));
    end
    dd_batch = ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 0)) : -1;
    dd_in_last = 1'($urandom_range(1, 0));
  endtask

  task automatic run(input int len);
    plan(len);
    exec(len, n);
    clear_in();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cond"},  16'(cc_data_condition), 16'd0);
    chk({tag, "_len"},   16'(cc_data_length),    16'd0);
    chk({tag, "_pus"},   16'(cc_pu_start),       16'd0);
    chk({tag, "_busy"},  16'(cc_busy),           16'd0);
    chk({tag, "_fin"},   16'(cc_finished),       16'd0);
    chk({tag, "_err"},   16'(cc_error),          16'd0);
    chk({tag, "_cnt"},   16'(cc_batch_count),    16'd0);
  endtask

  initial begin
    int pidx;
    cc_reset = 1'b1;
    cc_length = 6'd0;
    clear_in();
    #2;
    check_reset_values("reset");
    #10 cc_reset = 1'b0;

    // Nominal length 3 with a start pulse ignored while busy
    set_delays(5, 2, 5);
    plan(3);
    add_busy_start();
    exec(3, n);
    clear_in();

    // Reset asserted in the middle of PROC
    set_delays(2, 2, 8);
    plan(5);
    pidx = 0;
    for (int k = n - 1; k > 0; k--) if (e_pus[k]) pidx = k;
    exec(5, pidx + 3);
    #3 cc_reset = 1'b1;
    #1 check_reset_values("midreset");
    clear_in();
    #2 cc_reset = 1'b0;
    m_err = 1'b0; m_cnt = 0; m_len = 0;
    set_delays(3, 3, 4);
    run(3);

    // Length clamp: 40 -> 31, 32 batches
    set_delays(1, 2, 1);
    run(40);

    // Data-done during batch 2 of length 10
    set_delays(2, 3, 3);
    dd_batch = 1;
    run(10);
    set_delays(2, 2, 2);
    dd_batch = 2;
    dd_in_last = 1'b1;
    run(10);

    // Watchdog expiry in STORE, then a clean run clears the error
    set_delays(TI + 1, 2, 2);
    run(4);
    set_delays(1, 2, 2);
    run(0);

    // pu_done coinciding with watchdog expiry, done wins
    set_delays(1, 2, TI);
    run(2);

    // Watchdog expiry in FETCH and in PROC
    set_delays(1, 2, 2);
    f_d[1] = TI + 1;
    run(6);
    set_delays(1, TI, 1);
    p_d[0] = TI + 1;
    run(6);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      rand_delays();
      run(int'($urandom_range(40, 0)));
      repeat ($urandom_range(2, 0)) @(posedge cc_clk);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Core control sequencer for the memory controller's condition-code handshake. It drives the 3-bit data condition and 6-bit data length into the memory controller, tracks its done/data-done replies, and launches the processing units once per operand batch. A watchdog aborts any stalled phase cleanly. It sits between the host start/status interface and the memory controller / processing-unit cluster at top level.

## Interface
- TIMEOUT_CYCLES, 16'd1000: cycles allowed in STORE, FETCH or PROC before abort (16-bit).
- MEM_LENGTH, 6'd31: last valid memory address; batch limit clamp.
- cc_clk  in  1  sole clock, rising edge.
- cc_reset  in  1  asynchronous, active-high reset.
- cc_start  in  1  host start; sampled only in IDLE.
- cc_length  in  6  host last-address index; batches = min(cc_length, MEM_LENGTH)+1.
- cc_mc_done  in  1  memory controller done.
- cc_mc_data_done  in  1  memory controller end-of-memory flag.
- cc_pu_done  in  1  processing units finished current batch (1-cycle pulse or level).
- cc_data_condition  out  3  condition code to memory controller.
- cc_data_length  out  6  latched length to memory controller.
- cc_pu_start  out  1  1-cycle launch pulse to processing units.
- cc_busy  out  1  high in every state except IDLE.
- cc_finished  out  1  1-cycle pulse on normal completion.
- cc_error  out  1  sticky timeout flag; cleared by next accepted cc_start or reset.
- cc_batch_count  out  7  batches completed in current run.

## Operation
- Condition codes: 000 IDLE/finish, 100 LOAD, 001 PROCESS, 010 NEXT/halt, 011 HOLD (no-op).
- All outputs registered. Reset: condition 000, length 0, pu_start 0, busy 0, finished 0, error 0, batch_count 0, state IDLE, watchdog 0.
- IDLE: drive 000. On cc_start=1: latch cc_length clamped to MEM_LENGTH into cc_data_length, clear batch_count, cc_error, data-done flag; go STORE.
- STORE: drive 100. On cc_mc_done=1 go FETCH.
- FETCH: drive 011. The first cycle after entry ignores cc_mc_done (stale). On cc_mc_done=1 in any later cycle: drive 001 for one cycle, pulse cc_pu_start in the same cycle, go PROC.
- PROC: drive 011. On cc_pu_done=1: batch_count+1. If batch_count+1 == cc_data_length+1, or the data-done flag is set, go FINISH. Otherwise drive 010 for one cycle and go FETCH.
- FINISH: drive 000 for one cycle, pulse cc_finished, go IDLE.
- cc_mc_data_done=1 in any non-IDLE cycle sets a sticky data-done flag, which forces FINISH after the current batch.
- Watchdog: 16-bit counter, cleared on every state entry, increments each cycle in STORE/FETCH/PROC.
  - When it equals TIMEOUT_CYCLES-1 and the exit condition is not met, go ABORT.
  - ABORT sequence drives 010, 001, 000 on three consecutive cycles, sets cc_error in the first ABORT cycle, then returns to IDLE. No cc_finished and no cc_pu_start are issued.

## Timing
- cc_start -> cc_busy=1 and condition 100: next edge (1-cycle latency).
- cc_mc_done in STORE -> condition 011 next edge.
- Qualifying cc_mc_done in FETCH -> condition 001 and cc_pu_start next edge; both last exactly one cycle.
- cc_pu_done -> condition 010 (or 000 in FINISH) next edge; batch_count updates on the same edge.
- Simultaneous events:
  - cc_pu_done and timeout in the same cycle: done wins.
  - cc_mc_data_done and cc_pu_done in the same cycle: go FINISH.
  - cc_start while busy: ignored.
- Length 0 gives exactly one batch. Length ≥31 is clamped to 31, giving 32 batches; batch_count never exceeds 32.
- Reset mid-run: all outputs return to reset values immediately (asynchronous). Condition 000 returns the memory controller to idle on its own reset/handshake.

## Test plan
- Reset mid-PROC -> outputs immediately at reset values; next cc_start with cc_length=3 runs normally.
- cc_length=3, mc_done 5 cycles after LOAD, pu_done 4 cycles after each pu_start -> exactly 4 cc_pu_start pulses, codes 100,011,001,011,010,... then one 000; cc_finished once; cc_batch_count=4.
- cc_length=40 -> cc_data_length=31; 32 batches; cc_batch_count=32.
- cc_mc_data_done pulsed during batch 2 of cc_length=10 -> FINISH after batch 2 completes; cc_batch_count=2.
- TIMEOUT_CYCLES=8, cc_mc_done held low in STORE -> after 8 STORE cycles codes 010,001,000 follow; cc_error=1; cc_finished never asserts; cc_busy=0 afterwards.
- cc_pu_done and watchdog expiry in the same cycle -> normal NEXT (010); cc_error stays 0. cc_start pulsed during PROC is ignored.
